// File: rtl/systolic_matmul_if.sv
// Handshake and operand/result bus for the NxN systolic matrix multiplier.
interface systolic_matmul_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2*DW + $clog2(N)
);
  logic              start;
  logic              accumulate;
  logic [N*N*DW-1:0] a_flat;
  logic [N*N*DW-1:0] b_flat;
  logic              busy;
  logic              done;
  logic [N*N*AW-1:0] c_flat;

  modport master (
    output start, accumulate, a_flat, b_flat,
    input  busy, done, c_flat
  );

  modport slave (
    input  start, accumulate, a_flat, b_flat,
    output busy, done, c_flat
  );
endinterface

// File: rtl/systolic_matmul.sv
// Output-stationary NxN systolic multiplier: C = A*B or C += A*B, with
// skewed operand feed, registered MAC grid and a start/busy/done handshake.
module systolic_matmul #(
  parameter int unsigned N      = 3,
  parameter int unsigned DW     = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned AW     = 2*DW + $clog2(N)
) (
  input logic               clk,
  input logic               reset,
  systolic_matmul_if.slave  bus
);
  localparam int unsigned LAST = 3*N - 1;
  localparam int unsigned CW   = $clog2(3*N);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [N*N*DW-1:0] a_q, b_q;
  logic [N*N*AW-1:0] acc_flat, c_q;
  logic              done_q;
  logic              busy_c, accept, finish, clr;
  logic [DW-1:0]     west  [N];
  logic [DW-1:0]     north [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == RUN);
    accept = (state == IDLE) && bus.start;
    finish = (state == RUN) && (cnt == CW'(LAST));
    clr    = accept && !bus.accumulate;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        a_q <= bus.a_flat;
        b_q <= bus.b_flat;
        cnt <= '0;
      end else if (busy_c) begin
        cnt <= cnt + 1'b1;
      end
      if (finish) c_q <= acc_flat;
    end
  end

  // Skew: row i sees A(i,k-i), column j sees B(k-j,j); zero outside the window
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      west[i]  = '0;
      north[i] = '0;
    end
    if (busy_c) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned m = 0; m < N; m++) begin
          if (32'(cnt) == i + m) begin
            west[i]  = a_q[(i*N+m)*DW +: DW];
            north[i] = b_q[(m*N+i)*DW +: DW];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in, b_in;
      logic [AW-1:0] prod_ext;
      logic [AW-1:0] acc;

      if (j == 0) begin : g_wi
        assign a_in = west[i];
      end else begin : g_ai
        assign a_in = g_row[i].g_col[j-1].g_ea.a_out;
      end

      if (i == 0) begin : g_ni
        assign b_in = north[j];
      end else begin : g_bi
        assign b_in = g_row[i-1].g_col[j].g_sb.b_out;
      end

      // Edge PEs have no consumer for their forwarded operand, so no register
      if (j < N-1) begin : g_ea
        logic [DW-1:0] a_out;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) a_out <= '0;
          else        a_out <= a_in;
        end
      end

      if (i < N-1) begin : g_sb
        logic [DW-1:0] b_out;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) b_out <= '0;
          else        b_out <= b_in;
        end
      end

      if (SIGNED != 0) begin : g_sp
        logic signed [2*DW-1:0] p;
        assign p        = $signed(a_in) * $signed(b_in);
        assign prod_ext = AW'(p);
      end else begin : g_up
        logic [2*DW-1:0] p;
        assign p        = a_in * b_in;
        assign prod_ext = AW'(p);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc <= '0;
        else        acc <= (clr ? '0 : acc) + prod_ext;
      end

      assign acc_flat[(i*N+j)*AW +: AW] = acc;
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_q;
  assign bus.c_flat = c_q;
endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench: three multiplier instances (3x3 unsigned, 3x3 signed, 4x4 DW=4).
module tb_systolic_matmul;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_matmul_if #(.N(3), .DW(8), .AW(18)) u_if ();
  systolic_matmul_if #(.N(3), .DW(8), .AW(18)) s_if ();
  systolic_matmul_if #(.N(4), .DW(4), .AW(10)) q_if ();

  systolic_matmul #(.N(3), .DW(8), .SIGNED(0)) u_dut (.clk(clk), .reset(reset), .bus(u_if));
  systolic_matmul #(.N(3), .DW(8), .SIGNED(1)) s_dut (.clk(clk), .reset(reset), .bus(s_if));
  systolic_matmul #(.N(4), .DW(4), .SIGNED(0)) q_dut (.clk(clk), .reset(reset), .bus(q_if));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return u_if.done;
      1:       return s_if.done;
      default: return q_if.done;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return u_if.busy;
      1:       return s_if.busy;
      default: return q_if.busy;
    endcase
  endfunction

  function automatic logic [31:0] c_of(input int sel, input int r, input int c);
    case (sel)
      0:       return 32'(u_if.c_flat[(r*3+c)*18 +: 18]);
      1:       return 32'(s_if.c_flat[(r*3+c)*18 +: 18]);
      default: return 32'(q_if.c_flat[(r*4+c)*10 +: 10]);
    endcase
  endfunction

  // Called at a negedge; the following posedge is the accepting edge E0.
  task automatic start_op(input int sel, input logic [71:0] a, input logic [71:0] b,
                          input logic acc);
    case (sel)
      0: begin u_if.a_flat = a; u_if.b_flat = b; u_if.accumulate = acc; u_if.start = 1'b1; end
      1: begin s_if.a_flat = a; s_if.b_flat = b; s_if.accumulate = acc; s_if.start = 1'b1; end
      default: begin
        q_if.a_flat = a[63:0]; q_if.b_flat = b[63:0]; q_if.accumulate = acc; q_if.start = 1'b1;
      end
    endcase
    @(negedge clk);
    u_if.start = 1'b0;
    s_if.start = 1'b0;
    q_if.start = 1'b0;
  endtask

  // Counts posedges until done is seen (bounded), and busy-high cycles on the way.
  task automatic wait_done(input int sel, output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = 0;
    while (!done_of(sel) && edges < 60) begin
      if (busy_of(sel)) busy_cyc++;
      @(negedge clk);
      edges++;
    end
  endtask

  logic [71:0] a_id, b_seq, a_ff, a_5, a_80, b_7f;
  logic [71:0] a4, b4;
  int edges, bc, dcount;
  logic [31:0] exp_v;

  initial begin
    u_if.start = 0; u_if.accumulate = 0; u_if.a_flat = '0; u_if.b_flat = '0;
    s_if.start = 0; s_if.accumulate = 0; s_if.a_flat = '0; s_if.b_flat = '0;
    q_if.start = 0; q_if.accumulate = 0; q_if.a_flat = '0; q_if.b_flat = '0;

    a_id = '0; b_seq = '0; a_ff = '1; a_5 = '0; a_80 = '0; b_7f = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a_id[(r*3+c)*8 +: 8]  = (r == c) ? 8'd1 : 8'd0;
        b_seq[(r*3+c)*8 +: 8] = 8'(r*3 + c + 1);
        a_5[(r*3+c)*8 +: 8]   = 8'd5;
        a_80[(r*3+c)*8 +: 8]  = 8'h80;
        b_7f[(r*3+c)*8 +: 8]  = 8'h7f;
      end
    a4 = '0; b4 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a4[(r*4+c)*4 +: 4] = 4'(r + c);
        b4[(r*4+c)*4 +: 4] = 4'(r * c);
      end

    repeat (3) @(negedge clk);
    check("rst_busy_u", 32'(u_if.busy), 0);
    check("rst_done_u", 32'(u_if.done), 0);
    check("rst_c_u",    32'(|u_if.c_flat), 0);
    check("rst_c_q",    32'(|q_if.c_flat), 0);
    reset = 1'b1;
    @(negedge clk);

    // Identity times 1..9
    start_op(0, a_id, b_seq, 1'b0);
    check("t1_busy_early", 32'(u_if.busy), 1);
    wait_done(0, edges, bc);
    check("t1_latency", 32'(edges), 9);
    check("t1_busy_cycles", 32'(bc), 9);
    check("t1_busy_at_done", 32'(u_if.busy), 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("t1_c%0d%0d", r, c), c_of(0, r, c), 32'(r*3 + c + 1));
    @(negedge clk);
    check("t1_done_single", 32'(u_if.done), 0);

    // All-255 operands: 3*255*255
    start_op(0, a_ff, a_ff, 1'b0);
    wait_done(0, edges, bc);
    check("t2_latency", 32'(edges), 9);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("t2_c%0d%0d", r, c), c_of(0, r, c), 32'd195075);
    @(negedge clk);

    // Accumulate, second op started in the done cycle
    start_op(0, a_id, a_id, 1'b0);
    wait_done(0, edges, bc);
    check("t4a_latency", 32'(edges), 9);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("t4a_c%0d%0d", r, c), c_of(0, r, c), (r == c) ? 32'd1 : 32'd0);
    start_op(0, a_id, a_id, 1'b1);
    check("t4_done_single", 32'(u_if.done), 0);
    check("t4_busy_b2b", 32'(u_if.busy), 1);
    wait_done(0, edges, bc);
    check("t4b_latency", 32'(edges), 9);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("t4b_c%0d%0d", r, c), c_of(0, r, c), (r == c) ? 32'd2 : 32'd0);
    @(negedge clk);

    // Signed: (-128)*(-128)*3 = 49152, then (-128)*127*3 = -48768 mod 2^18
    start_op(1, a_80, a_80, 1'b0);
    wait_done(1, edges, bc);
    check("t3a_latency", 32'(edges), 9);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("t3a_c%0d%0d", r, c), c_of(1, r, c), 32'd49152);
    @(negedge clk);
    start_op(1, a_80, b_7f, 1'b0);
    wait_done(1, edges, bc);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("t3b_c%0d%0d", r, c), c_of(1, r, c), 32'd213376);
    @(negedge clk);

    // 4x4, DW=4: C(r,c) = sum_k (r+k)*k*c
    start_op(2, a4, b4, 1'b0);
    wait_done(2, edges, bc);
    check("t6_latency", 32'(edges), 12);
    check("t6_busy_cycles", 32'(bc), 12);
    check("t6_c33", c_of(2, 3, 3), 32'd96);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        exp_v = 0;
        for (int k = 0; k < 4; k++) exp_v += 32'((r + k) * k * c);
        check($sformatf("t6_c%0d%0d", r, c), c_of(2, r, c), exp_v);
      end
    @(negedge clk);

    // Mid-op start is ignored; c_flat holds the previous result while busy
    start_op(0, a_id, b_seq, 1'b0);
    repeat (4) @(negedge clk);
    check("t5_c_stable", c_of(0, 0, 0), 32'd2);
    u_if.a_flat = a_5;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(0, edges, bc);
    check("t5_latency_rest", 32'(edges), 4);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("t5_c%0d%0d", r, c), c_of(0, r, c), 32'(r*3 + c + 1));
    @(negedge clk);

    // Reset at cnt=5 abandons the operation
    start_op(0, a_id, b_seq, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5r_busy", 32'(u_if.busy), 0);
    check("t5r_done", 32'(u_if.done), 0);
    check("t5r_c", 32'(|u_if.c_flat), 0);
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.done) dcount++;
    end
    check("t5r_no_done", 32'(dcount), 0);
    check("t5r_idle", 32'(u_if.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
